// File: rtl/ppu_out_packer_if.sv
// Bundle between the PPU/GLB environment and the output packer: control, byte stream and GLB write port.
// master is the packer side; slave is the surrounding PPU/GLB/controller side.
interface ppu_out_packer_if #(
    parameter int ADDR_BITS = 12
);
    logic                 start;
    logic [ADDR_BITS-1:0] base_addr;
    logic [15:0]          total_bytes;
    logic                 in_valid;
    logic [7:0]           in_data;
    logic                 glb_we;
    logic [ADDR_BITS-1:0] glb_addr;
    logic [31:0]          glb_wdata;
    logic [3:0]           glb_wstrb;
    logic                 glb_ready;
    logic                 busy;
    logic                 done;
    logic                 overflow;

    modport master (
        input  start, base_addr, total_bytes, in_valid, in_data, glb_ready,
        output glb_we, glb_addr, glb_wdata, glb_wstrb, busy, done, overflow
    );

    modport slave (
        output start, base_addr, total_bytes, in_valid, in_data, glb_ready,
        input  glb_we, glb_addr, glb_wdata, glb_wstrb, busy, done, overflow
    );
endinterface

// File: rtl/ppu_out_packer.sv
// Packs the PPU int8 stream into 32-bit GLB words, buffers them in a small FIFO
// against GLB stalls, and pulses done once the tile's last word is written.
module ppu_out_packer #(
    parameter int ADDR_BITS  = 12,
    parameter int FIFO_DEPTH = 4
) (
    input logic              clk,
    input logic              rst,
    ppu_out_packer_if.master bus
);
    localparam int PTR_BITS = $clog2(FIFO_DEPTH);
    localparam logic [PTR_BITS:0]    CNT_ONE  = (PTR_BITS + 1)'(1);
    localparam logic [PTR_BITS:0]    CNT_FULL = (PTR_BITS + 1)'(FIFO_DEPTH);
    localparam logic [PTR_BITS-1:0]  PTR_ONE  = PTR_BITS'(1);
    localparam logic [ADDR_BITS-1:0] ADDR_ONE = ADDR_BITS'(1);

    typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_t;

    state_t state_reg, state_next;
    logic   done_reg, done_next;

    logic [1:0]           lane_reg;
    logic [15:0]          byte_cnt_reg;
    logic [15:0]          total_reg;
    logic [ADDR_BITS-1:0] push_addr_reg;
    logic                 overflow_reg;

    logic [31:0]          data_mem [FIFO_DEPTH];
    logic [3:0]           strb_mem [FIFO_DEPTH];
    logic [ADDR_BITS-1:0] addr_mem [FIFO_DEPTH];
    logic [PTR_BITS-1:0]  rd_ptr_reg, wr_ptr_reg;
    logic [PTR_BITS:0]    count_reg;

    logic        start_ok, accept, last_byte, push, pop, push_ok, drop;
    logic        fifo_empty, fifo_full;
    logic [31:0] push_word;
    logic [3:0]  push_strb;

    assign start_ok   = (state_reg == IDLE) && bus.start;
    assign accept     = (state_reg == RUN) && bus.in_valid;
    assign last_byte  = accept && ((byte_cnt_reg + 16'd1) == total_reg);
    assign push       = accept && ((lane_reg == 2'd3) || last_byte);
    assign fifo_empty = (count_reg == '0);
    assign fifo_full  = (count_reg == CNT_FULL);
    assign pop        = !fifo_empty && bus.glb_ready;
    // A full FIFO still accepts a push when the head leaves in the same cycle.
    assign push_ok    = push && (!fifo_full || pop);
    assign drop       = push && fifo_full && !pop;
    assign push_strb  = 4'hF >> (2'd3 - lane_reg);

    genvar gi;
    generate
        for (gi = 0; gi < 4; gi++) begin : g_lane
            logic [7:0] byte_reg;

            assign push_word[8*gi +: 8] = (lane_reg == 2'(gi)) ? bus.in_data : byte_reg;

            always_ff @(posedge clk) begin
                if (rst || start_ok || push) begin
                    byte_reg <= '0;
                end else if (accept && (lane_reg == 2'(gi))) begin
                    byte_reg <= bus.in_data;
                end
            end
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg <= IDLE;
            done_reg  <= 1'b0;
        end else begin
            state_reg <= state_next;
            done_reg  <= done_next;
        end
    end

    // Leave DRAIN on the edge that pops the last word so done and the fall of busy coincide.
    always_comb begin
        state_next = state_reg;
        done_next  = 1'b0;
        case (state_reg)
            IDLE: begin
                if (bus.start) begin
                    if (bus.total_bytes != 16'd0) begin
                        state_next = RUN;
                    end else begin
                        done_next = 1'b1;
                    end
                end
            end
            RUN: begin
                if (last_byte) begin
                    state_next = DRAIN;
                end
            end
            DRAIN: begin
                if (fifo_empty || ((count_reg == CNT_ONE) && pop)) begin
                    state_next = IDLE;
                    done_next  = 1'b1;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            lane_reg      <= '0;
            byte_cnt_reg  <= '0;
            total_reg     <= '0;
            push_addr_reg <= '0;
            overflow_reg  <= 1'b0;
        end else begin
            if (start_ok) begin
                lane_reg      <= '0;
                byte_cnt_reg  <= '0;
                total_reg     <= bus.total_bytes;
                push_addr_reg <= bus.base_addr;
                overflow_reg  <= 1'b0;
            end else if (accept) begin
                byte_cnt_reg <= byte_cnt_reg + 16'd1;
                lane_reg     <= push ? 2'd0 : lane_reg + 2'd1;
                // Dropped words still consume an address.
                if (push) begin
                    push_addr_reg <= push_addr_reg + ADDR_ONE;
                end
            end
            if (drop) begin
                overflow_reg <= 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (push_ok) begin
            data_mem[wr_ptr_reg] <= push_word;
            strb_mem[wr_ptr_reg] <= push_strb;
            addr_mem[wr_ptr_reg] <= push_addr_reg;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rd_ptr_reg <= '0;
            wr_ptr_reg <= '0;
            count_reg  <= '0;
        end else begin
            if (push_ok) begin
                wr_ptr_reg <= wr_ptr_reg + PTR_ONE;
            end
            if (pop) begin
                rd_ptr_reg <= rd_ptr_reg + PTR_ONE;
            end
            case ({push_ok, pop})
                2'b10:   count_reg <= count_reg + CNT_ONE;
                2'b01:   count_reg <= count_reg - CNT_ONE;
                default: count_reg <= count_reg;
            endcase
        end
    end

    assign bus.glb_we    = !fifo_empty;
    assign bus.glb_wdata = fifo_empty ? 32'd0 : data_mem[rd_ptr_reg];
    assign bus.glb_wstrb = fifo_empty ? 4'd0 : strb_mem[rd_ptr_reg];
    assign bus.glb_addr  = fifo_empty ? push_addr_reg : addr_mem[rd_ptr_reg];
    assign bus.busy      = (state_reg != IDLE);
    assign bus.done      = done_reg;
    assign bus.overflow  = overflow_reg;
endmodule

// File: tb/tb_ppu_out_packer.sv
// Scoreboard bench for ppu_out_packer: each tile's expected GLB writes are derived from the
// byte list and queued; an independent monitor checks every handshake against that queue.
module tb_ppu_out_packer;
    localparam int AB = 12;
    localparam int FD = 4;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    ppu_out_packer_if #(.ADDR_BITS(AB)) bus ();

    ppu_out_packer #(.ADDR_BITS(AB), .FIFO_DEPTH(FD)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    typedef struct packed {
        logic [AB-1:0] addr;
        logic [31:0]   data;
        logic [3:0]    strb;
    } wr_t;

    wr_t        exp_q[$];
    wr_t        mon_e;
    logic [7:0] tile_bytes[$];
    int errors = 0;
    int checks = 0;
    int cyc = 0;
    int n_writes = 0;
    int n_done = 0;
    int last_hs_cyc = -10;
    int done_cyc = -10;
    int ready_mode = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %0h, required %0h", name, act, req);
        end
    endtask

    always @(posedge clk) cyc <= cyc + 1;

    // Monitor: every handshake must match the head of the expected queue.
    always @(negedge clk) begin
        if (!rst) begin
            if (bus.glb_we && bus.glb_ready) begin
                n_writes++;
                last_hs_cyc = cyc;
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_write: got addr %0h data %0h strb %0h, required no write",
                             bus.glb_addr, bus.glb_wdata, bus.glb_wstrb);
                end else begin
                    mon_e = exp_q.pop_front();
                    check("wr_addr", 64'(bus.glb_addr), 64'(mon_e.addr));
                    check("wr_data", 64'(bus.glb_wdata), 64'(mon_e.data));
                    check("wr_strb", 64'(bus.glb_wstrb), 64'(mon_e.strb));
                    $display("write addr=%03h data=%08h strb=%b", bus.glb_addr, bus.glb_wdata, bus.glb_wstrb);
                end
            end
            if (bus.done) begin
                n_done++;
                done_cyc = cyc;
                check("busy_low_at_done", 64'(bus.busy), 64'd0);
            end
        end
    end

    // GLB ready: always high, always low, or random with at most 3 low cycles in a row.
    int low_run = 0;
    initial begin
        forever begin
            @(posedge clk);
            #1;
            case (ready_mode)
                0:       bus.glb_ready = 1'b1;
                1:       bus.glb_ready = 1'b0;
                default: bus.glb_ready = (low_run >= 3) ? 1'b1 : 1'($urandom_range(0, 1));
            endcase
            low_run = bus.glb_ready ? 0 : low_run + 1;
        end
    end

    task automatic reset_checks(input string tag);
        check({tag, "_glb_we"},    64'(bus.glb_we), 64'd0);
        check({tag, "_glb_addr"},  64'(bus.glb_addr), 64'd0);
        check({tag, "_glb_wdata"}, 64'(bus.glb_wdata), 64'd0);
        check({tag, "_glb_wstrb"}, 64'(bus.glb_wstrb), 64'd0);
        check({tag, "_busy"},      64'(bus.busy), 64'd0);
        check({tag, "_done"},      64'(bus.done), 64'd0);
        check({tag, "_overflow"},  64'(bus.overflow), 64'd0);
    endtask

    // Expected writes: word w holds bytes 4w..4w+3, strobes cover the present bytes,
    // address is base+w modulo 2^AB; only the first keep words survive.
    task automatic run_tile(input logic [AB-1:0] base, input int n, input int vmode,
                            input int keep, input bit extra_start);
        int  nw = (n + 3) / 4;
        int  i = 0;
        int  tog = 0;
        bit  v;
        wr_t e;
        for (int w = 0; w < nw && w < keep; w++) begin
            e.addr = base + AB'(w);
            e.data = '0;
            e.strb = '0;
            for (int b = 0; b < 4; b++) begin
                if (4 * w + b < n) begin
                    e.data[8*b +: 8] = tile_bytes[4 * w + b];
                    e.strb[b] = 1'b1;
                end
            end
            exp_q.push_back(e);
        end
        bus.start = 1'b1;
        bus.base_addr = base;
        bus.total_bytes = 16'(n);
        @(posedge clk);
        #1;
        bus.start = 1'b0;
        check("busy_after_start", 64'(bus.busy), 64'd1);
        while (i < n) begin
            case (vmode)
                0:       v = 1'b1;
                1:       v = (tog == 0);
                default: v = ($urandom_range(0, 3) != 0);
            endcase
            tog = 1 - tog;
            bus.in_valid = v;
            bus.in_data = v ? tile_bytes[i] : 8'($urandom);
            if (extra_start && i == 1) begin
                bus.start = 1'b1;
                bus.base_addr = ~base;
                bus.total_bytes = 16'd3;
            end
            @(posedge clk);
            #1;
            bus.start = 1'b0;
            bus.base_addr = base;
            if (v) i++;
        end
        bus.in_valid = 1'b1;
        bus.in_data = 8'hEE;
        repeat (2) @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
    endtask

    task automatic wait_done(input int done0, input int writes0, input int exp_writes,
                             input bit exp_ovf);
        int k = 0;
        while (n_done == done0 && k < 500) begin
            @(negedge clk);
            #1;
            k++;
        end
        if (n_done == done0) begin
            checks++;
            errors++;
            $display("FAIL done_timeout: got no done in 500 cycles, required one pulse");
        end else begin
            check("done_after_last_hs", 64'(done_cyc), 64'(last_hs_cyc + 1));
        end
        repeat (3) @(negedge clk);
        #1;
        check("done_pulses", 64'(n_done - done0), 64'd1);
        check("write_count", 64'(n_writes - writes0), 64'(exp_writes));
        check("overflow", 64'(bus.overflow), 64'(exp_ovf));
        check("queue_drained", 64'(exp_q.size()), 64'd0);
    endtask

    task automatic fill_bytes(input int n, input int mode);
        tile_bytes.delete();
        for (int i = 0; i < n; i++) begin
            case (mode)
                0:       tile_bytes.push_back(8'(8'h11 * (i + 1)));
                1:       tile_bytes.push_back(8'(8'hA1 + i));
                default: tile_bytes.push_back(8'($urandom));
            endcase
        end
    endtask

    initial begin
        int d0;
        int w0;
        int n;
        rst = 1'b1;
        bus.start = 1'b0;
        bus.base_addr = '0;
        bus.total_bytes = '0;
        bus.in_valid = 1'b0;
        bus.in_data = '0;
        bus.glb_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        reset_checks("reset");
        rst = 1'b0;

        // Full words, back-to-back
        fill_bytes(8, 0);
        d0 = n_done; w0 = n_writes;
        run_tile(12'h010, 8, 0, 99, 1'b0);
        wait_done(d0, w0, 2, 1'b0);

        // Partial last word with bubbles
        fill_bytes(6, 0);
        d0 = n_done; w0 = n_writes;
        run_tile(12'h020, 6, 1, 99, 1'b0);
        wait_done(d0, w0, 2, 1'b0);

        // Backpressure filling the FIFO exactly
        ready_mode = 1;
        fill_bytes(16, 2);
        d0 = n_done; w0 = n_writes;
        run_tile(12'h040, 16, 0, 99, 1'b0);
        check("bp16_no_writes", 64'(n_writes - w0), 64'd0);
        check("bp16_we", 64'(bus.glb_we), 64'd1);
        check("bp16_overflow", 64'(bus.overflow), 64'd0);
        ready_mode = 0;
        wait_done(d0, w0, 4, 1'b0);

        // Backpressure with one dropped word
        ready_mode = 1;
        fill_bytes(20, 2);
        d0 = n_done; w0 = n_writes;
        run_tile(12'h100, 20, 0, FD, 1'b0);
        check("bp20_overflow_set", 64'(bus.overflow), 64'd1);
        ready_mode = 0;
        wait_done(d0, w0, 4, 1'b1);
        check("bp20_addr_skipped", 64'(bus.glb_addr), 64'h105);

        // Reset clears sticky overflow and idle address
        @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        reset_checks("rst_after_ovf");

        // Address wrap
        fill_bytes(8, 2);
        d0 = n_done; w0 = n_writes;
        run_tile(12'hFFF, 8, 0, 99, 1'b0);
        wait_done(d0, w0, 2, 1'b0);

        // Reset mid-tile after 3 bytes, then a clean tile
        bus.start = 1'b1;
        bus.base_addr = 12'h200;
        bus.total_bytes = 16'd8;
        @(posedge clk);
        #1;
        bus.start = 1'b0;
        for (int i = 0; i < 3; i++) begin
            bus.in_valid = 1'b1;
            bus.in_data = 8'h55;
            @(posedge clk);
            #1;
        end
        bus.in_valid = 1'b0;
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        reset_checks("rst_mid_tile");
        fill_bytes(4, 1);
        d0 = n_done; w0 = n_writes;
        run_tile(12'h300, 4, 0, 99, 1'b0);
        wait_done(d0, w0, 1, 1'b0);

        // Zero-length tile
        d0 = n_done; w0 = n_writes;
        bus.start = 1'b1;
        bus.base_addr = 12'h400;
        bus.total_bytes = 16'd0;
        @(posedge clk);
        #1;
        bus.start = 1'b0;
        check("zero_done", 64'(bus.done), 64'd1);
        check("zero_busy", 64'(bus.busy), 64'd0);
        for (int i = 0; i < 3; i++) begin
            @(posedge clk);
            #1;
            check("zero_no_we", 64'(bus.glb_we), 64'd0);
            check("zero_busy_low", 64'(bus.busy), 64'd0);
        end
        check("zero_done_pulses", 64'(n_done - d0), 64'd1);
        check("zero_no_writes", 64'(n_writes - w0), 64'd0);

        // Random tiles with random bubbles, bounded ready stalls and ignored mid-tile starts
        ready_mode = 2;
        for (int t = 0; t < 16; t++) begin
            n = $urandom_range(1, 40);
            fill_bytes(n, 2);
            d0 = n_done; w0 = n_writes;
            run_tile(AB'($urandom), n, 2, 99, (t % 3) == 0);
            wait_done(d0, w0, (n + 3) / 4, 1'b0);
        end
        ready_mode = 0;

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: got simulation still running, required completion");
        $fatal(1, "watchdog expired");
    end
endmodule
